tmr32_duty_seq: RTL

TMR32_DUTY_SEQ -- requirements
Module: tmr32_duty_seq

---
 rtl/tmr32_duty_seq_if.sv | 20 ++
 rtl/tmr32_duty_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/tmr32_duty_seq_if.sv
// tmr32_duty_seq_if -- entry-push channel for the duty sequencer.
//   in_valid : producer offers an entry
//   in_ready : sequencer accepts the entry (in_valid && in_ready)
//   in_cmpx  : CMPX value of the offered entry
//   in_cmpy  : CMPY value of the offered entry
//   in_rep   : entry applies for in_rep+1 timer periods
// master = producer side, slave = sequencer side.
interface tmr32_duty_seq_if #(
    parameter int DW = 32,
    parameter int RW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_cmpx;
    logic [DW-1:0] in_cmpy;
    logic [RW-1:0] in_rep;

    modport master (output in_valid, in_cmpx, in_cmpy, in_rep, input in_ready);
    modport slave  (input in_valid, in_cmpx, in_cmpy, in_rep, output in_ready);
endinterface

// File: rtl/tmr32_duty_seq.sv
// tmr32_duty_seq -- feeds a PWM timer its CMPX/CMPY compare values from a
// small entry FIFO, advancing one entry per (rep+1) timer periods.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : sequencer enable (IDLE <-> WAIT/RUN)
//   flush      : synchronous clear of FIFO and repeat counter
//   in_if      : entry-push channel (valid/ready, cmpx, cmpy, rep)
//   period_evt : one-cycle pulse at the timer period boundary
//   cmpx, cmpy : compare values currently driven to the timer
//   ld         : one-cycle pulse when cmpx/cmpy take a new entry
//   busy       : high in WAIT and RUN
//   level      : FIFO occupancy
//   underrun   : one-cycle pulse when an entry was due but FIFO was empty
module tmr32_duty_seq #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int RW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    tmr32_duty_seq_if.slave          in_if,
    input  logic                     period_evt,
    output logic [DW-1:0]            cmpx,
    output logic [DW-1:0]            cmpy,
    output logic                     ld,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] mem_x [DEPTH];
    logic [DW-1:0] mem_y [DEPTH];
    logic [RW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cmpx_q, cmpy_q;
    logic          ld_q, urun_q;
    logic          full, empty, push, pop, urun;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign in_if.in_ready = !full;
    assign push  = in_if.in_valid && !full && !flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        urun    = 1'b0;
        if (flush) begin
            state_d = en ? S_WAIT : S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (en) state_d = S_WAIT;
                S_WAIT: begin
                    if (!en) state_d = S_IDLE;
                    else if (period_evt && !empty) begin
                        pop     = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!en) state_d = S_IDLE;
                    else if (period_evt) begin
                        if (cnt_q != '0) cnt_d = cnt_q - RW'(1);
                        else if (!empty) pop  = 1'b1;
                        else             urun = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (pop) cnt_d = mem_r[rd_ptr_q];
        end
    end

    always_comb begin
        level_d = level_q;
        if (flush) level_d = '0;
        else if (push && !pop) level_d = level_q + (AW+1)'(1);
        else if (!push && pop) level_d = level_q - (AW+1)'(1);
    end

    // Storage is not reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr_q] <= in_if.in_cmpx;
            mem_y[wr_ptr_q] <= in_if.in_cmpy;
            mem_r[wr_ptr_q] <= in_if.in_rep;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            cmpx_q   <= '0;
            cmpy_q   <= '0;
            ld_q     <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            ld_q    <= pop;
            urun_q  <= urun;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (pop) begin
                cmpx_q <= mem_x[rd_ptr_q];
                cmpy_q <= mem_y[rd_ptr_q];
            end
        end
    end

    assign cmpx     = cmpx_q;
    assign cmpy     = cmpy_q;
    assign ld       = ld_q;
    assign underrun = urun_q;
    assign level    = level_q;
    assign busy     = (state_q != S_IDLE);
endmodule
